aibcr3pnr_rst_seq: RTL and testbench
====================================

Name: aibcr3pnr_rst_seq

Overview:
Reset release sequencer that sits directly downstream of the per-domain reset synchronizer. It consumes the synchronized active-low reset and releases NUM_STAGES sub-block resets in a fixed order: stage 0 first, stage NUM_STAGES-1 last. Each release is spaced by a programmable delay and gated by a ready/ack from the previously released stage. An ack timeout is flagged as an error. Used in AIB channel bring-up to order adapter, FIFO and datapath resets.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs (1..8)
DLY_CYC, 8, clk cycles from previous ack (or reset exit) to the next stage release (>=1)
TMO_CYC, 1024, clk cycles allowed for a stage ack after its release (>=2)

Ports:
clk  input  1  sequencer clock; same clock as the upstream reset synchronizer
rst_n  input  1  synchronous active-low reset; driven by the synchronizer's rst_n_sync
scan_mode_n  input  1  0 = scan mode; all stage resets bypassed
rst_n_bypass  input  1  reset driven onto every stage output in scan mode
soft_rst_req  input  1  level-sensitive software re-sequence request
stage_ack  input  NUM_STAGES  per-stage ready; already synchronous to clk (caller guarantees this)
stage_rst_n  output  NUM_STAGES  sequenced active-low stage resets
seq_done  output  1  all stages released and acked
seq_err  output  1  ack timeout occurred
err_stage  output  max(1,$clog2(NUM_STAGES))  index of the stage that timed out

Behaviour:
- Reset is synchronous: rst_n sampled 0 at an edge gives state HOLD, stage_rst_n=0, seq_done=0, seq_err=0, err_stage=0, idx=0, cnt=0. Outputs do not change before that edge.
- States: HOLD, DLY, ACK, DONE, ERR. All outputs are registered, except for the scan mux.
- HOLD: at the first edge with rst_n=1 and soft_rst_req=0 (call it edge E), go to DLY with cnt=DLY_CYC-1 and idx=0.
- DLY: cnt decrements each edge. At the edge where cnt==0 is observed:
  - set stage_rst_n[idx]=1;
  - go to ACK with cnt=0.
  - Stage 0 therefore rises at edge E+DLY_CYC.
- ACK: if stage_ack[idx] is sampled 1 at edge A:
  - if idx==NUM_STAGES-1, go to DONE and set seq_done=1 at edge A;
  - otherwise increment idx and go to DLY with cnt=DLY_CYC-1, so the next stage rises at edge A+DLY_CYC.
- ACK timeout: if no ack, cnt increments each edge. At release edge R+TMO_CYC, go to ERR and set seq_err=1 and err_stage=idx.
- Ack and timeout on the same edge: ack wins.
- ERR: released stages stay released and unreleased stages stay held. Exit is only via rst_n or soft_rst_req.
- DONE: terminal. Later changes on stage_ack are ignored.
- Acks are sampled only for the current idx. Acks on other stages are ignored in every state.
- soft_rst_req=1 sampled at an edge, in any state:
  - go to HOLD, stage_rst_n=0, seq_done=0, seq_err=0, err_stage=0;
  - stay in HOLD while it is high;
  - the restart timing after it goes low equals the reset-exit timing.
- Priority: rst_n > soft_rst_req > ack > timeout.
- Scan: when scan_mode_n==0, stage_rst_n = {NUM_STAGES{rst_n_bypass}} combinationally. Internal state, seq_done, seq_err and err_stage are unaffected by scan.
- Counter: a single shared counter of width $clog2(max(DLY_CYC,TMO_CYC))+1. It never wraps, because it is reloaded on every state entry.

Decomposition:
- Package aibcr3pnr_rst_seq_pkg holds:
  - the state enum typedef (HOLD/DLY/ACK/DONE/ERR);
  - the counter-width function cnt_w(DLY_CYC,TMO_CYC);
  - the index-width function.
- No sub-module. One FSM plus one shared counter in a single module.

Test Plan:
(All scenarios use NUM_STAGES=3, DLY_CYC=4, TMO_CYC=16, with edge 0 = first edge with rst_n=1.)
1. Nominal: each ack rises 2 cycles after its release -> stage_rst_n[0] rises at edge 4, ack0 at 6; [1] at 10, ack1 at 12; [2] at 16, ack2 at 18; seq_done=1 after edge 18; seq_err=0 throughout.
2. Timeout: ack1 held 0 -> stage1 released at 10; seq_err=1 and err_stage=1 after edge 26; stage_rst_n=3'b011 held; seq_done=0.
3. Ack on the timeout edge: ack1 first sampled 1 at edge 26 -> no error; stage2 released at edge 30.
4. Soft reset mid-sequence: soft_rst_req high for one cycle, sampled at edge 12 -> stage_rst_n=0 after 12; restart from HOLD at edge 13; stage0 rises at edge 17.
5. Reset mid-ACK: rst_n=0 sampled at edge 11 with stages 0 and 1 released -> all outputs 0 after edge 11 and unchanged before it; after rst_n returns high, the sequence repeats with the scenario 1 timing.
6. Scan: scan_mode_n=0 while rst_n_bypass toggles 0/1/0 -> stage_rst_n follows as 000/111/000 with no clock edge needed; on scan exit, outputs return to the registered FSM values.

Source files
------------

// File: rtl/aibcr3pnr_rst_seq_pkg.sv
// Shared types and width helpers for the AIB reset release sequencer.
package aibcr3pnr_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_DLY,
    ST_ACK,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic int cnt_w(input int dly_cyc, input int tmo_cyc);
    int m;
    m = (dly_cyc > tmo_cyc) ? dly_cyc : tmo_cyc;
    return $clog2(m) + 1;
  endfunction

  function automatic int idx_w(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/aibcr3pnr_rst_seq.sv
// Releases NUM_STAGES sub-block resets in order, spaced by DLY_CYC and gated by
// each stage's ack; a missing ack within TMO_CYC parks the sequencer in ERR.
module aibcr3pnr_rst_seq
  import aibcr3pnr_rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int DLY_CYC    = 8,
  parameter int TMO_CYC    = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             scan_mode_n,
  input  logic                             rst_n_bypass,
  input  logic                             soft_rst_req,
  input  logic [NUM_STAGES-1:0]            stage_ack,
  output logic [NUM_STAGES-1:0]            stage_rst_n,
  output logic                             seq_done,
  output logic                             seq_err,
  output logic [idx_w(NUM_STAGES)-1:0]     err_stage
);

  localparam int CW = cnt_w(DLY_CYC, TMO_CYC);
  localparam int IW = idx_w(NUM_STAGES);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DLY_LOAD = CW'(DLY_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [IW-1:0]         es_q, es_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      es_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      err_q   <= err_d;
      es_q    <= es_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    err_d   = err_q;
    es_d    = es_q;
    if (soft_rst_req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      es_d    = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          state_d = ST_DLY;
          cnt_d   = DLY_LOAD;
          idx_d   = '0;
        end
        ST_DLY: begin
          if (cnt_q == '0) begin
            stage_d[idx_q] = 1'b1;
            state_d        = ST_ACK;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_ACK: begin
          // Ack is checked before the timeout so a same-edge ack still succeeds.
          if (stage_ack[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = ST_DLY;
              cnt_d   = DLY_LOAD;
            end
          end else if (cnt_q == TMO_LAST) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            es_d    = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_DONE, ST_ERR: begin
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign stage_rst_n = scan_mode_n ? stage_q : {NUM_STAGES{rst_n_bypass}};
  assign seq_done    = done_q;
  assign seq_err     = err_q;
  assign err_stage   = es_q;

endmodule

// File: tb/tb_aibcr3pnr_rst_seq.sv
// Randomized bench for the reset release sequencer; expectations come from an
// event-time schedule (release/ack/timeout edges) computed per scenario.
module tb_aibcr3pnr_rst_seq;

  localparam int N   = 3;
  localparam int DLY = 4;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         scan_mode_n;
  logic         rst_n_bypass;
  logic         soft_rst_req;
  logic [N-1:0] stage_ack;
  logic [N-1:0] stage_rst_n;
  logic         seq_done;
  logic         seq_err;
  logic [1:0]   err_stage;

  aibcr3pnr_rst_seq #(
    .NUM_STAGES(N),
    .DLY_CYC   (DLY),
    .TMO_CYC   (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_mode_n (scan_mode_n),
    .rst_n_bypass(rst_n_bypass),
    .soft_rst_req(soft_rst_req),
    .stage_ack   (stage_ack),
    .stage_rst_n (stage_rst_n),
    .seq_done    (seq_done),
    .seq_err     (seq_err),
    .err_stage   (err_stage)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scenario description: ack delay per stage (edges after release), and an
  // optional interruption (soft request or rst_n low) sampled at one edge.
  int   d[N];
  int   rr[N];
  int   intr_at;
  bit   intr_rst;
  int   epoch;
  logic [6:0] exp_v;

  wire [6:0] obs_v = {stage_rst_n, seq_done, seq_err, err_stage};

  // Release edge of each stage relative to reset exit; -1 if never reached.
  task automatic build_sched();
    int r;
    for (int j = 0; j < N; j++) rr[j] = -1;
    r = DLY;
    for (int j = 0; j < N; j++) begin
      rr[j] = r;
      if (d[j] > TMO) break;
      r = r + d[j] + DLY;
    end
  endtask

  function automatic logic [6:0] expect_at(input int u);
    logic [N-1:0] st;
    logic dn, er;
    logic [1:0] es;
    st = '0; dn = 1'b0; er = 1'b0; es = '0;
    for (int j = 0; j < N; j++) begin
      if (rr[j] < 0 || u < rr[j]) break;
      st[j] = 1'b1;
      if (d[j] > TMO) begin
        if (u >= rr[j] + TMO) begin
          er = 1'b1;
          es = 2'(j);
        end
        break;
      end
      if (u < rr[j] + d[j]) break;
      if (j == N - 1) dn = 1'b1;
    end
    return {st, dn, er, es};
  endfunction

  // Before a stage is waiting for its ack its ack line is random noise.
  function automatic logic [N-1:0] ack_at(input int u);
    logic [N-1:0] a;
    for (int j = 0; j < N; j++) begin
      if (rr[j] >= 0 && u > rr[j]) a[j] = (u >= rr[j] + d[j]);
      else                         a[j] = 1'($urandom_range(0, 1));
    end
    return a;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; soft_rst_req = 1'b0; stage_ack = 3'($urandom);
    @(posedge clk);
    @(negedge clk);
    stage_ack = 3'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for absolute edge t, take the edge, compute expected outputs.
  task automatic step(input int t);
    @(negedge clk);
    rst_n        = !(intr_rst && t == intr_at);
    soft_rst_req = (!intr_rst && t == intr_at);
    stage_ack    = ack_at(t - epoch);
    @(posedge clk);
    #1;
    if (t == intr_at) epoch = t + 1;
    exp_v = expect_at(t - epoch);
  endtask

  task automatic setup(input int d0, input int d1, input int d2, input int ia, input bit ir);
    d[0] = d0; d[1] = d1; d[2] = d2;
    intr_at = ia; intr_rst = ir; epoch = 0;
    build_sched();
    do_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; soft_rst_req = 1'b0; scan_mode_n = 1'b1; rst_n_bypass = 1'b0; stage_ack = '0;
    @(posedge clk);
    #1;
    checks++;
    if (obs_v !== 7'b0) begin
      errors++;
      $display("FAIL reset: got %b exp %b", obs_v, 7'b0);
    end
  endtask

  task automatic test_nominal();
    setup(2, 2, 2, -1, 1'b0);
    for (int t = 0; t < 30; t++) begin
      step(t);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL nominal t=%0d: got %b exp %b", t, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 3; k++) begin
      // delay 16 is an ack on the timeout edge; 17 is one edge too late
      if (k == 0)      setup(2, 100, 2, -1, 1'b0);
      else if (k == 1) setup(2, TMO, 2, -1, 1'b0);
      else             setup(2, TMO + 1, 2, -1, 1'b0);
      for (int t = 0; t < 50; t++) begin
        step(t);
        checks++;
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL timeout k=%0d t=%0d: got %b exp %b", k, t, obs_v, exp_v);
        end
      end
    end
  endtask

  task automatic test_soft_reset();
    setup(2, 2, 2, 12, 1'b0);
    for (int t = 0; t < 45; t++) begin
      step(t);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL soft_reset t=%0d: got %b exp %b", t, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_rst_mid_ack();
    setup(2, 2, 2, 11, 1'b1);
    for (int t = 0; t < 45; t++) begin
      step(t);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL rst_mid_ack t=%0d: got %b exp %b", t, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_scan();
    logic [2:0] byp [3];
    setup(2, 100, 2, -1, 1'b0);
    for (int t = 0; t < 40; t++) step(t);
    byp[0] = 3'b000; byp[1] = 3'b111; byp[2] = 3'b000;
    @(negedge clk);
    scan_mode_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rst_n_bypass = byp[i][0];
      #1;
      checks++;
      if (obs_v !== {byp[i], exp_v[3:0]}) begin
        errors++;
        $display("FAIL scan i=%0d: got %b exp %b", i, obs_v, {byp[i], exp_v[3:0]});
      end
    end
    scan_mode_n = 1'b1;
    #1;
    checks++;
    if (obs_v !== {3'b011, 1'b0, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL scan_exit: got %b exp %b", obs_v, {3'b011, 1'b0, 1'b1, 2'd1});
    end
  endtask

  task automatic test_random();
    int dd[N];
    int ia;
    bit ir;
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < N; j++)
        dd[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                            : int'($urandom_range(1, 6));
      ia = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 60));
      ir = 1'($urandom_range(0, 1));
      setup(dd[0], dd[1], dd[2], ia, ir);
      for (int t = 0; t < 140; t++) begin
        step(t);
        checks++;
        if (obs_v !== exp_v) begin
          errors++;
          $display("FAIL random it=%0d t=%0d: got %b exp %b", it, t, obs_v, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_soft_reset();
    test_rst_mid_ack();
    test_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
